// File: rtl/led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm
// Brief    : 8-channel LED PWM with per-channel blink gating and a tiny
//            register bus. Optional LED_PWM_READBACK_EN enables CTRL/DUTY/BLINK reads.
// Revision : 1.0  initial release
// ============================================================================
module led_pwm #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic [7:0]  leds
);

    localparam logic [15:0] C_PRESC_MAX  = 16'(PRESCALE - 1);
    localparam logic [1:0]  C_ADDR_CTRL  = 2'd0;
    localparam logic [1:0]  C_ADDR_DUTY  = 2'd1;
    localparam logic [1:0]  C_ADDR_BLINK = 2'd2;
    localparam logic [1:0]  C_ADDR_STAT  = 2'd3;

    logic [15:0] ctrl_q,  ctrl_d;
    logic [7:0]  duty_q,  duty_d;
    logic [15:0] blink_q, blink_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_q,   pwm_d;
    logic [15:0] bcnt_q,  bcnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  leds_q,  leds_d;

    logic w_wr;
    logic w_rd;
    logic w_step;
    logic w_period;
    logic w_lit;
    logic w_unused;

    assign w_wr     = stb & we;
    assign w_rd     = stb & ~we;
    assign w_step   = (presc_q == C_PRESC_MAX);
    assign w_period = w_step & (pwm_q == 8'hFF);
    assign w_lit    = (pwm_q < duty_q);
    assign w_unused = ^data_in[31:16];

    assign ack  = stb;
    assign leds = leds_q;

    always_comb begin
        ctrl_d  = ctrl_q;
        duty_d  = duty_q;
        blink_d = blink_q;
        if (w_wr) begin
            case (addr)
                C_ADDR_CTRL:  ctrl_d  = data_in[15:0];
                C_ADDR_DUTY:  duty_d  = data_in[7:0];
                C_ADDR_BLINK: blink_d = data_in[15:0];
                default:      ;
            endcase
        end
    end

    always_comb begin
        presc_d = w_step ? 16'd0 : presc_q + 16'd1;
        pwm_d   = w_step ? pwm_q + 8'd1 : pwm_q;
    end

    // A BLINK write restarts the blink sequence even on a coincident period pulse.
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (w_wr && (addr == C_ADDR_BLINK)) begin
            bcnt_d  = 16'd0;
            phase_d = 1'b1;
        end else if (blink_q == 16'd0) begin
            bcnt_d  = 16'd0;
            phase_d = 1'b1;
        end else if (w_period) begin
            if (bcnt_q == (blink_q - 16'd1)) begin
                bcnt_d  = 16'd0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_led
        assign leds_d[gi] = ctrl_q[gi] & w_lit & (~ctrl_q[8+gi] | phase_q);
    end

    always_comb begin
        data_out = 32'd0;
        if (w_rd) begin
            case (addr)
                C_ADDR_STAT:  data_out = {23'd0, phase_q, pwm_q};
`ifdef LED_PWM_READBACK_EN
                C_ADDR_CTRL:  data_out = {16'd0, ctrl_q};
                C_ADDR_DUTY:  data_out = {24'd0, duty_q};
                C_ADDR_BLINK: data_out = {16'd0, blink_q};
`endif
                default:      data_out = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= 16'd0;
            duty_q  <= 8'd0;
            blink_q <= 16'd0;
            presc_q <= 16'd0;
            pwm_q   <= 8'd0;
            bcnt_q  <= 16'd0;
            phase_q <= 1'b1;
            leds_q  <= 8'd0;
        end else begin
            ctrl_q  <= ctrl_d;
            duty_q  <= duty_d;
            blink_q <= blink_d;
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            leds_q  <= leds_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm
// Brief    : Self-checking bench for led_pwm against a time-arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_pwm;

    localparam int P   = 4;
    localparam int PER = 256 * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [7:0]  leds;

    int passed = 0;
    int total  = 0;

    // Model state: n = rising edges since reset release, w = edge of last BLINK write.
    int          n;
    int          w;
    logic [15:0] m_ctrl;
    logic [7:0]  m_duty;
    logic [15:0] m_blink;
    logic [7:0]  m_leds;

    typedef struct {
        logic        stb;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_do;
        logic        exp_ack;
    } vec_t;
    vec_t vecs[8];

    led_pwm #(.PRESCALE(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .leds     (leds)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [7:0] pwm_at(input int k);
        return 8'((k / P) % 256);
    endfunction

    function automatic logic phase_at(input int k);
        int cnt;
        if (m_blink == 16'd0) return 1'b1;
        cnt = k / PER - w / PER;
        return 1'b1 ^ 1'((cnt / int'(m_blink)) % 2);
    endfunction

    function automatic logic [7:0] model_leds();
        logic [7:0] r;
        logic       lit;
        lit = (pwm_at(n) < m_duty);
        for (int i = 0; i < 8; i++)
            r[i] = m_ctrl[i] & lit & (~m_ctrl[8+i] | phase_at(n));
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd3: return {23'd0, phase_at(n), pwm_at(n)};
`ifdef LED_PWM_READBACK_EN
            2'd0: return {16'd0, m_ctrl};
            2'd1: return {24'd0, m_duty};
            2'd2: return {16'd0, m_blink};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        n = 0; w = 0;
        m_ctrl = '0; m_duty = '0; m_blink = '0; m_leds = '0;
    endtask

    // One clock: advance model with the inputs presented at the edge, then compare.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m_leds = model_leds();
            n++;
            if (stb && we) begin
                case (addr)
                    2'd0: m_ctrl = data_in[15:0];
                    2'd1: m_duty = data_in[7:0];
                    2'd2: begin m_blink = data_in[15:0]; w = n; end
                    default: ;
                endcase
            end
        end
        #1;
        chk("leds", leds, m_leds);
        chk("ack", ack, stb);
        chk("data_out", data_out, (stb && !we) ? model_read(addr) : 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        cyc();
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [1:0] a, input logic [31:0] exp);
        stb = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(name, data_out, exp);
        chk({name, "_ack"}, ack, 1'b1);
        stb = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    initial begin
        int cnt [8];
        int dark;
        int other;
        bit found;

        rst = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
        model_reset();

`ifdef LED_PWM_READBACK_EN
        vecs[0] = '{1'b1, 1'b0, 2'd0, 32'd0, 32'h0181, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 2'd1, 32'd0, 32'h005A, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'd0, 32'h0003, 1'b1};
`else
        vecs[0] = '{1'b1, 1'b0, 2'd0, 32'd0, 32'h0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 2'd1, 32'd0, 32'h0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'd0, 32'h0, 1'b1};
`endif
        vecs[3] = '{1'b1, 1'b0, 2'd3, 32'd0,          32'h100, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 2'd1, 32'd0,          32'h0,   1'b0};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF,  32'h0,   1'b1};
        vecs[6] = '{1'b0, 1'b1, 2'd3, 32'd0,          32'h0,   1'b0};
        vecs[7] = '{1'b0, 1'b0, 2'd3, 32'd0,          32'h0,   1'b0};

        // Reset state, including a write presented while held in reset.
        run(2);
        rdchk("reset_status", 2'd3, 32'h100);
        wr(2'd0, 32'h00FF);
        rst = 1'b1;
        rdchk("release_status", 2'd3, 32'h100);

        // Three writes complete before the first PWM step.
        wr(2'd0, 32'h0181);
        wr(2'd1, 32'h0000_005A);
        wr(2'd2, 32'h0000_0003);
        for (int i = 0; i < 8; i++) begin
            stb = vecs[i].stb; we = vecs[i].we; addr = vecs[i].addr; data_in = vecs[i].data;
            #1;
            chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_do);
            chk($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
        end
        stb = 1'b0; we = 1'b0;

        // Each channel lit for a quarter of the period.
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd64);
        wr(2'd0, 32'h00FF);
        run(2);
        for (int b = 0; b < 8; b++) cnt[b] = 0;
        for (int i = 0; i < PER; i++) begin
            cyc();
            for (int b = 0; b < 8; b++) if (leds[b]) cnt[b]++;
        end
        for (int b = 0; b < 8; b++) chk($sformatf("duty64_bit%0d", b), cnt[b], 256);

        // Blink on channel 0 only: two periods on, two off.
        wr(2'd0, 32'h0101);
        wr(2'd1, 32'd255);
        wr(2'd2, 32'd2);
        run(2);
        cnt[0] = 0; other = 0;
        for (int i = 0; i < 4 * PER; i++) begin
            cyc();
            if (leds[0]) cnt[0]++;
            if (leds[7:1] != 7'd0) other++;
        end
        chk("blink2_on_cycles", cnt[0], 2 * 255 * P);
        chk("blink2_others", other, 0);

        // DUTY 0 stays dark, DUTY 255 dark for one step per period.
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h00FF);
        run(2);
        other = 0;
        for (int i = 0; i < 4 * PER; i++) begin
            cyc();
            if (leds != 8'd0) other++;
        end
        chk("duty0_lit_cycles", other, 0);
        wr(2'd1, 32'd255);
        run(2);
        dark = 0;
        for (int i = 0; i < PER; i++) begin
            cyc();
            if (leds == 8'd0) dark++;
        end
        chk("duty255_dark_cycles", dark, P);

        // BLINK write on the same edge as a toggling period pulse.
        wr(2'd2, 32'd2);
        found = 1'b0;
        for (int i = 0; i < 4 * PER; i++) begin
            if (((n + 1) % PER == 0) && ((n + 1) / PER > w / PER) &&
                ((((n + 1) / PER - w / PER) % 2) == 0)) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk("toggle_sync_found", found, 1'b1);
        wr(2'd2, 32'd2);
        rdchk("coincident_status", 2'd3, 32'h100);
        run(PER);
        rdchk("after_1_period", 2'd3, 32'h100);
        run(PER);
        rdchk("after_2_periods", 2'd3, 32'h000);

        // Asynchronous reset with leds = 0x81.
        wr(2'd0, 32'h0181);
        wr(2'd1, 32'd255);
        wr(2'd2, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 2 * PER; i++) begin
            cyc();
            if (m_leds == 8'h81) begin found = 1'b1; break; end
        end
        chk("leds81_reached", found, 1'b1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_reset_leds", leds, 8'h00);
        rdchk("reset_mid_status", 2'd3, 32'h100);
        wr(2'd1, 32'd100);
        run(1);
        rst = 1'b1;
        rdchk("post_release_status", 2'd3, 32'h100);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            stb  = 1'($urandom_range(0, 1));
            we   = stb && ($urandom_range(0, 15) == 0);
            addr = 2'($urandom_range(0, 3));
            data_in = $urandom;
            if (addr == 2'd2) data_in[15:0] = 16'($urandom_range(0, 3));
            cyc();
        end
        stb = 1'b0; we = 1'b0;
        run(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
